// File: rtl/serializador_pkg.sv
// Shared definitions for the word serializer: FSM state encoding.
package serializador_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SHIFT  = S_SHIFT,
    ST_PARITY = S_PARITY,
    ST_DONE   = S_DONE
  } state_t;

endpackage

// File: rtl/registrador_deslocamento.sv
// Loadable right-shift register; exposes only bit 0 to the serializer.
// One cycle from load/shift to new lsb; load wins over shift.
module registrador_deslocamento #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data_in,
  output logic         lsb
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= data_in;
    end else if (shift) begin
      q <= q >> 1;
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/serializador_palavra.sv
// Word serializer: accepts BITS+1 bits, emits LSB-first, one bit per consumer handshake,
// optional even parity bit when SERIALIZADOR_PARIDADE_EN is defined, then a one-cycle done pulse.
// Bit k appears the cycle after edge k; serialReady low freezes serialOut/serialValid.
module serializador_palavra
  import serializador_pkg::*;
#(
  parameter int BITS = 63
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BITS:0] dataIn,
  input  logic          inValid,
  output logic          inReady,
  output logic          serialOut,
  output logic          serialValid,
  input  logic          serialReady,
  output logic          busy,
  output logic          done
);

  localparam int CW = (BITS > 0) ? $clog2(BITS + 1) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          load;
  logic          shift;
  logic          last;
  logic          sr_lsb;

  assign load  = (state == ST_IDLE) && inValid;
  assign shift = (state == ST_SHIFT) && serialReady;
  assign last  = (cnt == CW'(BITS));

  registrador_deslocamento #(
    .W(BITS + 1)
  ) u_sr (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .shift  (shift),
    .data_in(dataIn),
    .lsb    (sr_lsb)
  );

`ifdef SERIALIZADOR_PARIDADE_EN
  logic par;

  always_ff @(posedge clk) begin
    if (reset) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ^dataIn;
    end
  end
`endif

  // Counter saturates at BITS; the FSM leaves SHIFT on that handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (shift && !last) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    inReady     = 1'b0;
    serialValid = 1'b0;
    serialOut   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        inReady = 1'b1;
        busy    = 1'b0;
        if (inValid) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        serialValid = 1'b1;
        serialOut   = sr_lsb;
        if (serialReady && last) begin
`ifdef SERIALIZADOR_PARIDADE_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef SERIALIZADOR_PARIDADE_EN
      ST_PARITY: begin
        serialValid = 1'b1;
        serialOut   = par;
        if (serialReady) begin
          state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serializador_palavra.sv
// Scoreboard bench for serializador_palavra with BITS=7; parity bits expected only when
// SERIALIZADOR_PARIDADE_EN is defined.
module tb_serializador_palavra;

  localparam int BITS = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [BITS:0] dataIn;
  logic          inValid;
  logic          inReady;
  logic          serialOut;
  logic          serialValid;
  logic          serialReady;
  logic          busy;
  logic          done;

  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  logic exp_q[$];
  logic mon_e;

  always #5 clk = ~clk;

  serializador_palavra #(
    .BITS(BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dataIn     (dataIn),
    .inValid    (inValid),
    .inReady    (inReady),
    .serialOut  (serialOut),
    .serialValid(serialValid),
    .serialReady(serialReady),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [BITS:0] w);
    for (int i = 0; i <= BITS; i++) exp_q.push_back(w[i]);
`ifdef SERIALIZADOR_PARIDADE_EN
    exp_q.push_back(^w);
`endif
    done_exp++;
  endtask

  // Returns 1 time unit after the accepting edge (edge 0).
  task automatic accept(input logic [BITS:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!inReady && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", inReady, 1);
    dataIn  = w;
    inValid = 1'b1;
    push_word(w);
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_pulse", done, 1);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", inReady, 1);
  endtask

  // Monitor: every consumed bit is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && serialValid === 1'b1 && serialReady === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL serial_extra: got bit %0b expected none at %0t", serialOut, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("serial_bit", serialOut, mon_e);
        end
      end
      if (done === 1'b1) done_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    inValid     = 1'b0;
    dataIn      = '0;
    serialReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inReady", inReady, 1);
    chk("rst_serialValid", serialValid, 0);
    chk("rst_serialOut", serialOut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    // Full-rate A5: 8 consecutive valid cycles, then done, then ready.
    accept(8'hA5);
    for (int k = 0; k <= BITS; k++) begin
      @(negedge clk);
      chk("a5_valid", serialValid, 1);
      chk("a5_busy", busy, 1);
      chk("a5_inReady_low", inReady, 0);
    end
`ifdef SERIALIZADOR_PARIDADE_EN
    @(negedge clk);
    chk("a5_parity_valid", serialValid, 1);
`endif
    @(negedge clk);
    chk("a5_done", done, 1);
    chk("a5_done_valid", serialValid, 0);
    chk("a5_done_inReady", inReady, 0);
    @(negedge clk);
    chk("a5_done_gone", done, 0);
    chk("a5_inReady_back", inReady, 1);
    chk("a5_busy_gone", busy, 0);

    accept(8'h01);
    wait_done();

    // Backpressure while bit 2 of A5 (a 1) is presented.
    accept(8'hA5);
    @(posedge clk);
    @(posedge clk);
    #1 serialReady = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_held", serialOut, 1);
      chk("bp_valid_held", serialValid, 1);
      @(posedge clk);
    end
    #1 serialReady = 1'b1;
    wait_done();

    // New word offered mid-transfer must be ignored.
    accept(8'hA5);
    @(posedge clk);
    #1;
    dataIn  = 8'hFF;
    inValid = 1'b1;
    repeat (3) @(posedge clk);
    #1 inValid = 1'b0;
    wait_done();
    repeat (2) begin
      @(negedge clk);
      chk("ign_no_restart", busy, 0);
    end

    // Reset while bit 4 (a 0) is presented.
    accept(8'hA5);
    repeat (4) @(posedge clk);
    #1;
    chk("rst4_valid", serialValid, 1);
    chk("rst4_bit", serialOut, 0);
    reset       = 1'b1;
    serialReady = 1'b0;
    @(posedge clk);
    #1;
    chk("rst4_inReady", inReady, 1);
    chk("rst4_serialValid", serialValid, 0);
    chk("rst4_busy", busy, 0);
    chk("rst4_done", done, 0);
    chk("rst4_serialOut", serialOut, 0);
    exp_q.delete();
    done_exp--;
    reset       = 1'b0;
    serialReady = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst4_no_done", done, 0);
    end

    accept(8'h3C);
    wait_done();

    repeat (2) @(negedge clk);
    chk("done_count", done_seen, done_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
